// File: rtl/relogio_pkg.sv
// relogio_pkg: shared types, 7-segment table and 12 h conversion for the adjustable clock
package relogio_pkg;
  typedef enum logic [1:0] {RUN, SET_H, SET_M} estado_t;
  typedef struct packed {
    logic pm;
    logic [7:0] bcd;
  } hora12_t;
  localparam logic [6:0] SEG_APAGADO = 7'h00;
  localparam logic [9:0][6:0] SEG_TAB = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                         7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  function automatic hora12_t hora_12h(input logic [7:0] bcd24);
    hora12_t r;
    logic [4:0] h, h12;
    h = 5'(bcd24[7:4]) * 5'd10 + 5'(bcd24[3:0]);
    h12 = (h == 5'd0) ? 5'd12 : (h > 5'd12) ? h - 5'd12 : h;
    r.pm = h >= 5'd12;
    r.bcd = (h12 >= 5'd10) ? {4'd1, 4'(h12 - 5'd10)} : {4'd0, h12[3:0]};
    return r;
  endfunction
endpackage

// File: rtl/bcd_7seg.sv
// bcd_7seg: active-high {g,f,e,d,c,b,a} encoder, codes A-F blank
module bcd_7seg
  import relogio_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = (bcd < 4'd10) ? SEG_TAB[bcd] : SEG_APAGADO;
endmodule

// File: rtl/contador_bcd_mod.sv
// contador_bcd_mod: two-digit BCD counter wrapping at {MAX_MSD,MAX_LSD} with carry out
module contador_bcd_mod #(
  parameter logic [3:0] MAX_MSD = 4'd5,
  parameter logic [3:0] MAX_LSD = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] msd,
  output logic [3:0] lsd,
  output logic       carry
);
  logic no_max;
  assign no_max = (msd == MAX_MSD) && (lsd == MAX_LSD);
  assign carry = inc & no_max;
  always_ff @(posedge clk)
    if (rst || clr) {msd, lsd} <= 8'h00;
    else if (inc) {msd, lsd} <= no_max ? 8'h00 : (lsd == 4'd9) ? {msd + 4'd1, 4'd0} : {msd, lsd + 4'd1};
endmodule

// File: rtl/relogio_ajustavel.sv
// relogio_ajustavel: 24 h clock with hour/minute setting, blink, 12 h display and 7-segment/BCD outputs
module relogio_ajustavel
  import relogio_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter bit SEG_ATIVO_BAIXO = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       modo_12h,
  input  logic       btn_modo,
  input  logic       btn_inc,
  output logic [6:0] h_msd,
  output logic [6:0] h_lsd,
  output logic [6:0] m_msd,
  output logic [6:0] m_lsd,
  output logic [6:0] s_msd,
  output logic [6:0] s_lsd,
  output logic [7:0] bcd_h,
  output logic [7:0] bcd_m,
  output logic [7:0] bcd_s,
  output logic       pm,
  output logic       tick_1hz,
  output logic       ajustando
);
  localparam int PW = $clog2(CLK_HZ);
  estado_t estado;
  logic [PW-1:0] presc;
  logic btn_modo_q, btn_inc_q, ev_modo, ev_inc, fim, meio, run;
  logic inc_s, inc_m, inc_h, clr_s, c_s, c_m, c_h_unused;
  logic [3:0] hm, hl, mm, ml, sm, sl;
  hora12_t h12;
  logic [5:0][3:0] dig;
  logic [5:0] apaga;
  logic [5:0][6:0] seg_raw, seg;
  assign ev_modo = btn_modo & ~btn_modo_q;
  assign ev_inc = btn_inc & ~btn_inc_q & ~ev_modo;
  assign fim = presc == PW'(CLK_HZ - 1);
  assign meio = presc >= PW'(CLK_HZ / 2);
  assign run = estado == RUN;
  assign tick_1hz = fim;
  assign inc_s = run & fim & ~ev_modo;
  assign clr_s = run & ev_modo;
  assign inc_m = run ? c_s : (estado == SET_M) & ev_inc;
  assign inc_h = run ? c_m : (estado == SET_H) & ev_inc;
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      estado <= RUN;
      ajustando <= 1'b0;
      presc <= '0;
      btn_modo_q <= 1'b1;
      btn_inc_q <= 1'b1;
    end else begin
      btn_modo_q <= btn_modo;
      btn_inc_q <= btn_inc;
      presc <= ((ev_modo && estado != SET_H) || fim) ? '0 : presc + PW'(1);
      if (ev_modo) begin
        estado <= run ? SET_H : (estado == SET_H) ? SET_M : RUN;
        ajustando <= run || estado == SET_H;
      end
    end
  contador_bcd_mod #(.MAX_MSD(4'd5), .MAX_LSD(4'd9)) u_seg (
    .clk(CLOCK_50), .rst(reset), .inc(inc_s), .clr(clr_s), .msd(sm), .lsd(sl), .carry(c_s));
  contador_bcd_mod #(.MAX_MSD(4'd5), .MAX_LSD(4'd9)) u_min (
    .clk(CLOCK_50), .rst(reset), .inc(inc_m), .clr(1'b0), .msd(mm), .lsd(ml), .carry(c_m));
  contador_bcd_mod #(.MAX_MSD(4'd2), .MAX_LSD(4'd3)) u_hora (
    .clk(CLOCK_50), .rst(reset), .inc(inc_h), .clr(1'b0), .msd(hm), .lsd(hl), .carry(c_h_unused));
  assign h12 = hora_12h({hm, hl});
  assign bcd_h = modo_12h ? h12.bcd : {hm, hl};
  assign bcd_m = {mm, ml};
  assign bcd_s = {sm, sl};
  assign pm = modo_12h & h12.pm;
  assign dig = {bcd_h, bcd_m, bcd_s};
  assign apaga = {{2{estado == SET_H && meio}}, {2{estado == SET_M && meio}}, 2'b00};
  for (genvar d = 0; d < 6; d++) begin : g_dig
    bcd_7seg u_conv (.bcd(dig[d]), .seg(seg_raw[d]));
    assign seg[d] = (apaga[d] ? SEG_APAGADO : seg_raw[d]) ^ {7{SEG_ATIVO_BAIXO}};
  end
  assign {h_msd, h_lsd, m_msd, m_lsd, s_msd, s_lsd} = seg;
endmodule

// File: tb/tb_relogio_ajustavel.sv
// tb_relogio_ajustavel: directed self-checking bench for relogio_ajustavel at CLK_HZ=10
module tb_relogio_ajustavel;
  logic clk = 1'b0, reset = 1'b1, modo_12h = 1'b0, btn_modo = 1'b0, btn_inc = 1'b0;
  logic [6:0] h_msd, h_lsd, m_msd, m_lsd, s_msd, s_lsd;
  logic [7:0] bcd_h, bcd_m, bcd_s;
  logic pm, tick_1hz, ajustando;
  int n_vec = 0, n_err = 0;
  relogio_ajustavel #(.CLK_HZ(10), .SEG_ATIVO_BAIXO(1'b1)) dut (
    .CLOCK_50(clk), .reset(reset), .modo_12h(modo_12h), .btn_modo(btn_modo), .btn_inc(btn_inc),
    .h_msd(h_msd), .h_lsd(h_lsd), .m_msd(m_msd), .m_lsd(m_lsd), .s_msd(s_msd), .s_lsd(s_lsd),
    .bcd_h(bcd_h), .bcd_m(bcd_m), .bcd_s(bcd_s), .pm(pm), .tick_1hz(tick_1hz), .ajustando(ajustando));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic m, input logic i);
    btn_modo = m;
    btn_inc = i;
    @(negedge clk);
    btn_modo = 1'b0;
    btn_inc = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    step(3);
    chk("rst_h", bcd_h, 8'h00);
    chk("rst_m", bcd_m, 8'h00);
    chk("rst_s", bcd_s, 8'h00);
    chk("rst_tick", {7'd0, tick_1hz}, 8'h00);
    chk("rst_aj", {7'd0, ajustando}, 8'h00);
    chk("rst_hmsd", {1'b0, h_msd}, 8'h40);
    chk("rst_slsd", {1'b0, s_lsd}, 8'h40);
    reset = 1'b0;
    step(8);
    chk("pre_tick", {7'd0, tick_1hz}, 8'h00);
    step(1);
    chk("tick1", {7'd0, tick_1hz}, 8'h01);
    chk("s_before", bcd_s, 8'h00);
    step(1);
    chk("s_after", bcd_s, 8'h01);
    chk("slsd_1", {1'b0, s_lsd}, 8'h79);
    chk("tick_off", {7'd0, tick_1hz}, 8'h00);
    press(1, 0);
    chk("seth_aj", {7'd0, ajustando}, 8'h01);
    chk("seth_s", bcd_s, 8'h00);
    for (int i = 0; i < 5; i++) press(0, 1);
    chk("seth_h5", bcd_h, 8'h05);
    chk("seth_s0", bcd_s, 8'h00);
    press(1, 0);
    for (int i = 0; i < 61; i++) press(0, 1);
    chk("setm_m1", bcd_m, 8'h01);
    chk("setm_h5", bcd_h, 8'h05);
    chk("setm_aj", {7'd0, ajustando}, 8'h01);
    press(1, 0);
    chk("run_aj", {7'd0, ajustando}, 8'h00);
    step(7);
    chk("ret_notick", {7'd0, tick_1hz}, 8'h00);
    step(1);
    chk("ret_tick", {7'd0, tick_1hz}, 8'h01);
    step(1);
    chk("ret_s", bcd_s, 8'h01);
    chk("ret_m", bcd_m, 8'h01);
    chk("ret_h", bcd_h, 8'h05);
    press(1, 0);
    for (int i = 0; i < 8; i++) press(0, 1);
    chk("h13_24", bcd_h, 8'h13);
    chk("h13_pm24", {7'd0, pm}, 8'h00);
    modo_12h = 1'b1;
    #1;
    chk("h13_12", bcd_h, 8'h01);
    chk("h13_pm12", {7'd0, pm}, 8'h01);
    chk("blink_h", {1'b0, h_lsd}, 8'h7F);
    for (int i = 0; i < 11; i++) press(0, 1);
    chk("h00_12", bcd_h, 8'h12);
    chk("h00_pm", {7'd0, pm}, 8'h00);
    modo_12h = 1'b0;
    #1;
    chk("h00_24", bcd_h, 8'h00);
    for (int i = 0; i < 23; i++) press(0, 1);
    press(1, 0);
    chk("blk_mlsd7", {1'b0, m_lsd}, 8'h7F);
    chk("blk_mmsd7", {1'b0, m_msd}, 8'h7F);
    chk("blk_bcdm", bcd_m, 8'h01);
    chk("blk_hlsd", {1'b0, h_lsd}, 8'h30);
    step(3);
    chk("vis_mlsd0", {1'b0, m_lsd}, 8'h79);
    chk("vis_mmsd0", {1'b0, m_msd}, 8'h40);
    step(4);
    chk("vis_mlsd4", {1'b0, m_lsd}, 8'h79);
    step(1);
    chk("blk_mmsd5", {1'b0, m_msd}, 8'h7F);
    press(1, 1);
    chk("both_aj", {7'd0, ajustando}, 8'h00);
    chk("both_m", bcd_m, 8'h01);
    chk("both_h", bcd_h, 8'h23);
    press(0, 1);
    chk("run_inc_m", bcd_m, 8'h01);
    chk("run_inc_h", bcd_h, 8'h23);
    press(1, 0);
    press(1, 0);
    for (int i = 0; i < 58; i++) press(0, 1);
    press(1, 0);
    chk("r_s0", bcd_s, 8'h00);
    chk("r_m59", bcd_m, 8'h59);
    chk("r_h23", bcd_h, 8'h23);
    step(589);
    chk("r_s59", bcd_s, 8'h59);
    chk("r_notick", {7'd0, tick_1hz}, 8'h00);
    step(9);
    chk("r_tick", {7'd0, tick_1hz}, 8'h01);
    chk("r_pre_h", bcd_h, 8'h23);
    chk("r_pre_m", bcd_m, 8'h59);
    chk("r_pre_s", bcd_s, 8'h59);
    step(1);
    chk("roll_h", bcd_h, 8'h00);
    chk("roll_m", bcd_m, 8'h00);
    chk("roll_s", bcd_s, 8'h00);
    press(1, 0);
    chk("pre_rst_aj", {7'd0, ajustando}, 8'h01);
    btn_inc = 1'b1;
    modo_12h = 1'b1;
    reset = 1'b1;
    step(2);
    chk("rs_aj", {7'd0, ajustando}, 8'h00);
    chk("rs_h", bcd_h, 8'h12);
    chk("rs_m", bcd_m, 8'h00);
    chk("rs_s", bcd_s, 8'h00);
    chk("rs_pm", {7'd0, pm}, 8'h00);
    chk("rs_hmsd", {1'b0, h_msd}, 8'h79);
    chk("rs_hlsd", {1'b0, h_lsd}, 8'h24);
    chk("rs_tick", {7'd0, tick_1hz}, 8'h00);
    reset = 1'b0;
    step(3);
    chk("held_h", bcd_h, 8'h12);
    chk("held_aj", {7'd0, ajustando}, 8'h00);
    btn_inc = 1'b0;
    step(2);
    press(0, 1);
    chk("held_run_h", bcd_h, 8'h12);
    chk("held_run_m", bcd_m, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
